// File: rtl/if_fetch_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
// The master modport is the fetch stage itself; slave is its environment.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_inst_enable;
  logic        id_illegal;

  modport master (
    output imem_req, imem_addr,
    output id_valid, id_pc, id_inst, id_inst_enable, id_illegal,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    input  id_valid, id_pc, id_inst, id_inst_enable, id_illegal,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    output id_ready
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// and presents fetched words to decode with a one-hot active-low opcode enable.
//
// state | meaning
// FETCH | request outstanding at pc_q
// FULL  | response parked in skid buffer, no request
// KILL  | draining a request made stale by redirect (address in kill_addr_q)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst,
  if_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    KILL  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] kill_addr_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_inst_q;

  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic [31:0] id_inst_enable_q;
  logic        id_illegal_q;

  logic        slot_free;
  logic [31:0] pc_inc;
  logic        load_en;
  logic        bubble_en;
  logic [31:0] load_pc;
  logic [31:0] load_word;

  function automatic logic [31:0] inst_enable(input logic [31:0] w);
    if (w[1:0] == 2'b11) return ~(32'd1 << w[6:2]);
    return 32'hFFFF_FFFF;
  endfunction

  assign slot_free = !id_valid_q || bus.id_ready;
  assign pc_inc    = pc_q + 32'd4;

  assign bus.imem_req  = !rst && (state_q != FULL);
  assign bus.imem_addr = (state_q == KILL) ? kill_addr_q : pc_q;

  assign bus.id_valid       = id_valid_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_inst        = id_inst_q;
  assign bus.id_inst_enable = id_inst_enable_q;
  assign bus.id_illegal     = id_illegal_q;

  // What the output registers take next edge: a new word, a bubble, or hold.
  always_comb begin
    load_en   = 1'b0;
    bubble_en = 1'b0;
    load_pc   = pc_q;
    load_word = bus.imem_rdata;
    if (bus.redirect) begin
      bubble_en = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_ack && slot_free) load_en = 1'b1;
          else if (bus.id_ready)         bubble_en = 1'b1;
        end
        FULL: begin
          if (bus.id_ready) begin
            load_en   = 1'b1;
            load_pc   = skid_pc_q;
            load_word = skid_inst_q;
          end
        end
        KILL: begin
          if (bus.id_ready) bubble_en = 1'b1;
        end
        default: bubble_en = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= FETCH;
      pc_q             <= RESET_PC;
      kill_addr_q      <= 32'h0;
      skid_pc_q        <= 32'h0;
      skid_inst_q      <= 32'h0;
      id_valid_q       <= 1'b0;
      id_pc_q          <= 32'h0;
      id_inst_q        <= NOP;
      id_inst_enable_q <= 32'hFFFF_FFFF;
      id_illegal_q     <= 1'b0;
    end else begin
      if (load_en) begin
        id_valid_q       <= 1'b1;
        id_pc_q          <= load_pc;
        id_inst_q        <= load_word;
        id_inst_enable_q <= inst_enable(load_word);
        id_illegal_q     <= (load_word[1:0] != 2'b11);
      end else if (bubble_en) begin
        id_valid_q       <= 1'b0;
        id_pc_q          <= 32'h0;
        id_inst_q        <= NOP;
        id_inst_enable_q <= 32'hFFFF_FFFF;
        id_illegal_q     <= 1'b0;
      end

      if (bus.redirect) begin
        pc_q <= {bus.redirect_pc[31:2], 2'b00};
        // An unacked request is still in flight and must be drained first.
        case (state_q)
          FETCH: begin
            if (bus.imem_ack) begin
              state_q <= FETCH;
            end else begin
              state_q     <= KILL;
              kill_addr_q <= pc_q;
            end
          end
          KILL: begin
            if (bus.imem_ack) state_q <= FETCH;
          end
          default: state_q <= FETCH;
        endcase
      end else begin
        case (state_q)
          FETCH: begin
            if (bus.imem_ack) begin
              pc_q <= pc_inc;
              if (!slot_free) begin
                skid_pc_q   <= pc_q;
                skid_inst_q <= bus.imem_rdata;
                state_q     <= FULL;
              end
            end
          end
          FULL: begin
            if (bus.id_ready) state_q <= FETCH;
          end
          KILL: begin
            if (bus.imem_ack) state_q <= FETCH;
          end
          default: state_q <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a latency-programmable memory model feeds a scoreboard of
// expected (pc, inst) pairs that are popped whenever decode accepts an output.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_if bus ();
  if_fetch_if hi_bus ();

  if_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (hi_bus)
  );

  // Second instance only exercises PC wrap: zero-wait memory, decode always ready.
  assign hi_bus.imem_ack    = hi_bus.imem_req;
  assign hi_bus.imem_rdata  = NOP;
  assign hi_bus.redirect    = 1'b0;
  assign hi_bus.redirect_pc = 32'h0;
  assign hi_bus.id_ready    = 1'b1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [64];
  int          n_chk = 0;
  int          n_err = 0;
  int          mem_lat = 1;
  int          wait_cnt = 0;
  bit          mem_auto = 1'b1;
  logic [31:0] exp_pc = 32'h0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return mem[addr[7:2]];
  endfunction

  function automatic logic [31:0] exp_en(input logic [31:0] w);
    logic [31:0] e;
    e = 32'hFFFF_FFFF;
    if (w[1:0] == 2'b11) e[w[6:2]] = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return {12'(i * 3), 5'(i), 3'b000, 5'(i + 1), 5'(i), 2'b11};
  endfunction

  // Memory model: acks after mem_lat request cycles; in-order fetches go to the scoreboard.
  initial forever begin
    @(negedge clk);
    #1;
    if (mem_auto) begin
      bus.imem_ack = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (bus.imem_req) begin
        if (wait_cnt >= mem_lat - 1) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          wait_cnt       = 0;
          if (!bus.redirect && bus.imem_addr == exp_pc) begin
            sb.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
            exp_pc += 32'd4;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (bus.id_valid && bus.id_ready) begin
        if (sb.size() == 0) begin
          chk("sb_size", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_pc", bus.id_pc, e.pc);
          chk("sb_inst", bus.id_inst, e.inst);
          chk("sb_enable", bus.id_inst_enable, exp_en(e.inst));
          chk("sb_illegal", 32'(bus.id_illegal), 32'(e.inst[1:0] != 2'b11));
        end
      end else if (!bus.id_valid) begin
        chk("bubble_inst", bus.id_inst, NOP);
        chk("bubble_enable", bus.id_inst_enable, 32'hFFFF_FFFF);
      end
    end
  end

  // Leaves the bench at the negedge where rst drops (first cycle out of reset).
  task automatic do_reset(input int lat);
    @(negedge clk);
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    @(negedge clk);
    mem_lat  = lat;
    wait_cnt = 0;
    exp_pc   = 32'h0;
    sb.delete();
    #2;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_inst", bus.id_inst, NOP);
    chk("rst_enable", bus.id_inst_enable, 32'hFFFF_FFFF);
    chk("rst_illegal", 32'(bus.id_illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready    = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);

    // zero-wait first fetch
    mem[0] = 32'h0050_0093;
    bus.id_ready = 1'b1;
    do_reset(1);
    #2;
    chk("t1_req", 32'(bus.imem_req), 32'd1);
    chk("t1_addr0", bus.imem_addr, 32'h0);
    @(negedge clk); #2;
    chk("t1_valid", 32'(bus.id_valid), 32'd1);
    chk("t1_pc", bus.id_pc, 32'h0);
    chk("t1_enable", bus.id_inst_enable, 32'hFFFF_FFEF);
    chk("t1_illegal", 32'(bus.id_illegal), 32'd0);
    chk("t1_addr4", bus.imem_addr, 32'h4);
    repeat (4) @(negedge clk);

    // three-cycle memory, lui stream
    for (int i = 0; i < 3; i++) mem[i] = 32'h0000_12B7;
    do_reset(3);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      chk("t2_req_hold", 32'(bus.imem_req), 32'd1);
      chk("t2_wait_valid", 32'(bus.id_valid), 32'd0);
    end
    @(negedge clk); #2;
    chk("t2_pc0", bus.id_pc, 32'h0);
    chk("t2_enable", bus.id_inst_enable, 32'hFFFF_DFFF);
    repeat (7) @(negedge clk);
    #3;
    chk("t2_drain", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 3; i++) mem[i] = init_word(i);

    // back-pressure parks one fetch in the skid buffer
    bus.id_ready = 1'b0;
    do_reset(1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #2;
      chk("t3_req_parked", 32'(bus.imem_req), 32'd0);
      chk("t3_hold_valid", 32'(bus.id_valid), 32'd1);
      chk("t3_hold_pc", bus.id_pc, 32'h0);
    end
    @(negedge clk);
    bus.id_ready = 1'b1;
    #2 chk("t3_rel_pc0", bus.id_pc, 32'h0);
    @(negedge clk); #2 chk("t3_rel_pc4", bus.id_pc, 32'h4);
    @(negedge clk); #2 chk("t3_rel_pc8", bus.id_pc, 32'h8);

    // redirect while the request to 0x10 is waiting on a slow ack
    do_reset(3);
    n = 0;
    while (bus.imem_addr !== 32'h10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_0x10", bus.imem_addr, 32'h10);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    bus.id_ready    = 1'b0;
    sb.delete();
    exp_pc = 32'h100;
    @(negedge clk);
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready    = 1'b1;
    #2;
    chk("t4_flush_valid", 32'(bus.id_valid), 32'd0);
    chk("t4_stale_addr", bus.imem_addr, 32'h10);
    chk("t4_stale_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk); #2;
    chk("t4_kill_addr", bus.imem_addr, 32'h10);
    @(negedge clk); #2;
    chk("t4_new_addr", bus.imem_addr, 32'h100);
    chk("t4_still_bubble", 32'(bus.id_valid), 32'd0);
    repeat (3) @(negedge clk);
    #2 chk("t4_target_pc", bus.id_pc, 32'h100);
    @(negedge clk);
    #3 chk("t4_drain", 32'(sb.size()), 32'd0);

    // illegal encodings, plus PC wrap on the high-reset instance
    mem[0] = 32'h0000_0001;
    mem[1] = 32'h0000_0002;
    do_reset(1);
    #2 chk("t5_hi_addr_top", hi_bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #2;
    chk("t5_illegal", 32'(bus.id_illegal), 32'd1);
    chk("t5_ill_enable", bus.id_inst_enable, 32'hFFFF_FFFF);
    chk("t5_ill_inst", bus.id_inst, 32'h0000_0001);
    chk("t5_hi_addr_wrap", hi_bus.imem_addr, 32'h0);
    chk("t5_hi_pc", hi_bus.id_pc, 32'hFFFF_FFFC);
    chk("t5_hi_valid", 32'(hi_bus.id_valid), 32'd1);
    @(negedge clk); #2;
    chk("t5_illegal2", 32'(bus.id_illegal), 32'd1);
    chk("t5_hi_pc_wrap", hi_bus.id_pc, 32'h0);
    mem[0] = init_word(0);
    mem[1] = init_word(1);
    repeat (2) @(negedge clk);

    // reset lands during KILL together with an ack that must be dropped
    do_reset(3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    exp_pc          = 32'h40;
    @(negedge clk);
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    mem_auto        = 1'b0;
    rst             = 1'b1;
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 32'h0BAD_C0B3;
    #2 chk("t6_req_in_rst", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    rst          = 1'b0;
    wait_cnt     = 0;
    exp_pc       = 32'h0;
    sb.delete();
    mem_auto     = 1'b1;
    #2;
    chk("t6_valid", 32'(bus.id_valid), 32'd0);
    chk("t6_addr", bus.imem_addr, 32'h0);
    chk("t6_inst", bus.id_inst, NOP);
    repeat (3) @(negedge clk);
    #2 chk("t6_first_pc", bus.id_pc, 32'h0);
    repeat (4) @(negedge clk);
    #3 chk("t6_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage directly upstream of the decode stage. It owns the PC register and issues single-outstanding requests to instruction memory. It registers the returned word together with its PC and a one-hot active-low opcode-enable vector (the inst_enable format decode consumes), and handles decode back-pressure and redirects from branch/jump/trap resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
imem_req  output  1  fetch request; held high with imem_addr stable until imem_ack.
imem_addr  output  32  word-aligned fetch address.
imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle; may coincide with the first imem_req cycle.
imem_rdata  input  32  fetched instruction.
redirect  input  1  one-cycle pulse; flush and restart fetch at redirect_pc.
redirect_pc  input  32  new PC; bits [1:0] ignored (forced to 00).
id_ready  input  1  decode accepts the current output this cycle.
id_valid  output  1  output registers hold a live instruction.
id_pc  output  32  PC of id_inst.
id_inst  output  32  instruction word.
id_inst_enable  output  32  active-low one-hot of id_inst[6:2]; all ones when invalid or illegal.
id_illegal  output  1  live instruction has inst[1:0] != 2'b11.

Behaviour:
- States: FETCH (request outstanding), FULL (response parked in skid buffer, no request), KILL (draining a request made stale by redirect).
- Reset (rst=1 at an edge):
  - pc_q=RESET_PC, state=FETCH, skid empty.
  - id_valid=0, id_pc=0, id_inst=32'h0000_0013, id_inst_enable=32'hFFFF_FFFF, id_illegal=0.
  - imem_req=0 during any cycle with rst=1.
- FETCH:
  - imem_req=1, imem_addr=pc_q.
  - On imem_ack, if the output slot is free (id_valid=0, or id_ready=1): load the output registers next edge, pc_q+=4 (mod 2^32, wraps 0xFFFF_FFFC->0), stay FETCH.
  - On imem_ack with the slot occupied and id_ready=0: store word+PC in skid, pc_q+=4, go FULL.
- FULL:
  - imem_req=0.
  - When id_ready=1: skid moves to the output registers, skid empties, go FETCH.
- KILL:
  - imem_req=1, imem_addr=stale address.
  - On imem_ack: discard the data, go FETCH at pc_q (already the redirect target).
- Redirect (priority over all except rst):
  - pc_q<=redirect_pc&~3.
  - Output registers go to the bubble values (as at reset) next edge regardless of id_ready.
  - Skid cleared.
  - Request outstanding and no imem_ack this cycle -> KILL.
  - imem_ack in the same cycle -> data discarded, go FETCH.
  - Redirect while in KILL: update pc_q, stay KILL.
- Output register update:
  - Output holds its value while id_valid=1 and id_ready=0.
  - If id_ready=1 and nothing is loaded: bubble next edge.
- Decode of the loaded word w:
  - w[1:0]==2'b11: id_inst_enable has bit w[6:2] =0, all others 1; id_illegal=0.
  - Otherwise: id_inst_enable=all ones, id_illegal=1.
  - id_inst=w in both cases.
- Bubbles always present id_inst=NOP 0x00000013 and id_inst_enable=all ones, so decode sees no load/store/write enables.
- Latency: with zero-wait memory (ack in the request cycle), id_valid rises one edge after the request; sustained throughput is 1 instruction/cycle.
- Mid-operation reset overrides KILL/FULL and any pending ack; an ack arriving in the rst cycle is dropped.

Test Plan:
- Reset, zero-wait memory returns 0x00500093 at addr 0 -> cycle after first req: id_valid=1, id_pc=0, id_inst_enable=0xFFFFFFEF, id_illegal=0; next imem_addr=4.
- Stream of 0x000012B7 (lui) with id_ready=1 and 3-cycle ack latency -> imem_req stays high 3 cycles per fetch; each output has id_inst_enable=0xFFFFDFFF and id_pc=0,4,8.
- Hold id_ready=0 for 5 cycles after the first valid output -> one fetch parked (FULL), imem_req=0, id_* stable; release -> outputs PC 0, then 4, then 8 on consecutive accepted cycles.
- Redirect to 0x00000103 while a req to 0x10 is outstanding and ack lags 2 cycles -> next edge id_valid=0; ack data ignored; next imem_addr=0x100.
- Ack carrying 0x00000001 -> id_illegal=1, id_inst_enable=0xFFFFFFFF; RESET_PC=0xFFFFFFFC -> second fetch address 0x00000000.
- Assert rst during KILL with an ack in the same cycle -> after reset: id_valid=0, imem_addr=RESET_PC, and no discarded or stale data ever appears on id_inst.
